mesh_loader: RTL

- Upstream feeder for the subdivision core.
- Receives an input mesh as a framed byte stream over a valid/ready interface and packs bytes into 32-bit little-endian words.
- Writes the words into the input DFFRAM512x32 (ram0) through that RAM's single port, then pulses start to subsurf and tracks busy until the core finishes.
- Top level muxes ram0's port between loader and core using ram_own.

---
 rtl/mesh_loader.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/mesh_loader.sv
// Purpose: unpacks a length-framed byte stream into 32-bit LE words, loads ram0, then kicks subsurf and tracks busy.
// Latency: a word is written the cycle after its 4th byte; start follows the last write by one cycle.
// Backpressure: s_ready drops during WRITE, START and both busy-wait states; input stalls are held indefinitely.
module mesh_loader #(
    parameter int ADDR_W    = 9,
    parameter int MAX_WORDS = 512,
    parameter int BUSY_TO   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    input  logic [7:0]        s_data,
    output logic              s_ready,
    output logic              ram_own,
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [ADDR_W-1:0] ram_a,
    output logic [31:0]       ram_di,
    output logic              start,
    input  logic              busy,
    output logic              done,
    output logic              err
);
    // Word index is one bit wider than the address so a full 512-word frame can count past 511.
    localparam int WI_W = ADDR_W + 1;
    localparam int TO_W = $clog2(BUSY_TO + 1);
    localparam int DR_W = 18;

    typedef enum logic [2:0] {
        S_IDLE, S_HDR1, S_DATA, S_WRITE, S_START, S_WAIT_HI, S_WAIT_LO, S_DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       n_q, n_d;
    logic [WI_W-1:0]   word_q, word_d;
    logic [1:0]        byte_q, byte_d;
    logic [31:0]       asm_q, asm_d;
    logic [DR_W-1:0]   drain_q, drain_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic              own_q, own_d;
    logic              en_q, en_d;
    logic [3:0]        we_q, we_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [31:0]       di_q, di_d;
    logic              start_q, start_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              acc;
    logic [15:0]       hdr_n;

    assign s_ready = (state_q == S_IDLE) || (state_q == S_HDR1) ||
                     (state_q == S_DATA) || (state_q == S_DRAIN);
    assign acc     = s_valid && s_ready;
    assign hdr_n   = {s_data, n_q[7:0]};

    assign ram_own = own_q;
    assign ram_en  = en_q;
    assign ram_we  = we_q;
    assign ram_a   = a_q;
    assign ram_di  = di_q;
    assign start   = start_q;
    assign done    = done_q;
    assign err     = err_q;

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            n_q     <= '0;
            word_q  <= '0;
            byte_q  <= '0;
            asm_q   <= '0;
            drain_q <= '0;
            to_q    <= '0;
            own_q   <= 1'b1;
            en_q    <= 1'b0;
            we_q    <= '0;
            a_q     <= '0;
            di_q    <= '0;
            start_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
            asm_q   <= asm_d;
            drain_q <= drain_d;
            to_q    <= to_d;
            own_q   <= own_d;
            en_q    <= en_d;
            we_q    <= we_d;
            a_q     <= a_d;
            di_q    <= di_d;
            start_q <= start_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic; RAM strobes and status pulses default low, address/data hold.
    always_comb begin
        state_d = state_q;
        n_d     = n_q;
        word_d  = word_q;
        byte_d  = byte_q;
        asm_d   = asm_q;
        drain_d = drain_q;
        to_d    = to_q;
        own_d   = own_q;
        en_d    = 1'b0;
        we_d    = 4'h0;
        a_d     = a_q;
        di_d    = di_q;
        start_d = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    n_d     = {8'h00, s_data};
                    state_d = S_HDR1;
                end
            end
            S_HDR1: begin
                if (acc) begin
                    n_d = hdr_n;
                    if (hdr_n == 16'd0) begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end else if (hdr_n > 16'(MAX_WORDS)) begin
                        err_d   = 1'b1;
                        drain_d = {hdr_n, 2'b00};
                        state_d = S_DRAIN;
                    end else begin
                        word_d  = '0;
                        byte_d  = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (acc) begin
                    asm_d[{byte_q, 3'b000} +: 8] = s_data;
                    if (byte_q == 2'd3) begin
                        // Launch the write straight from the 4th byte so it lands next cycle.
                        en_d    = 1'b1;
                        we_d    = 4'hF;
                        a_d     = word_q[ADDR_W-1:0];
                        di_d    = {s_data, asm_q[23:0]};
                        byte_d  = '0;
                        state_d = S_WRITE;
                    end else begin
                        byte_d = byte_q + 2'd1;
                    end
                end
            end
            S_WRITE: begin
                word_d = word_q + 1'b1;
                if (16'(word_q) == n_q - 16'd1) begin
                    start_d = 1'b1;
                    own_d   = 1'b0;
                    state_d = S_START;
                end else begin
                    state_d = S_DATA;
                end
            end
            S_START: begin
                to_d    = '0;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (busy) begin
                    state_d = S_WAIT_LO;
                end else if (to_q == TO_W'(BUSY_TO - 1)) begin
                    err_d   = 1'b1;
                    own_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!busy) begin
                    done_d  = 1'b1;
                    own_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (acc) begin
                    drain_d = drain_q - 1'b1;
                    if (drain_q == DR_W'(1)) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
